// File: rtl/obi_sram_xbar.sv
// N-master OBI arbiter in front of a single-port SRAM with 1-cycle read latency.
// Fixed or round-robin arbitration, per-port response routing, error response
// for unmapped addresses and a byte-writable GPIO output register.

// Per-port response steering: only the port that owns the pending response sees it.
module obi_sram_xbar_port (
  input  logic        rsp_vld,
  input  logic        is_mem,
  input  logic        is_gpio,
  input  logic        is_err,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] gpio_rdata,
  output logic        rvalid,
  output logic        err,
  output logic [31:0] rdata
);
  // rdata is forced to zero whenever this port has no response
  always_comb begin
    rvalid = rsp_vld;
    err    = rsp_vld & is_err;
    rdata  = '0;
    if (rsp_vld) begin
      if (is_mem)       rdata = mem_rdata;
      else if (is_gpio) rdata = gpio_rdata;
    end
  end
endmodule

module obi_sram_xbar #(
  parameter int          NumPorts  = 2,
  parameter int          ArbMode   = 0,
  parameter int          MemSize   = 64*1024,
  parameter logic [31:0] MemStart  = 32'h0000_0000,
  parameter logic [31:0] GpioAddr  = 32'h8000_0000,
  parameter int          GpioWidth = 8
) (
  input  logic                         clk_sys,
  input  logic                         rst_sys_n,
  input  logic [NumPorts-1:0]          req_i,
  input  logic [NumPorts-1:0]          we_i,
  input  logic [NumPorts-1:0][3:0]     be_i,
  input  logic [NumPorts-1:0][31:0]    addr_i,
  input  logic [NumPorts-1:0][31:0]    wdata_i,
  output logic [NumPorts-1:0]          gnt_o,
  output logic [NumPorts-1:0]          rvalid_o,
  output logic [NumPorts-1:0][31:0]    rdata_o,
  output logic [NumPorts-1:0]          err_o,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [3:0]                   mem_be_o,
  output logic [31:0]                  mem_addr_o,
  output logic [31:0]                  mem_wdata_o,
  input  logic [31:0]                  mem_rdata_i,
  output logic [GpioWidth-1:0]         gpio_o
);
  localparam int          PtrW    = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam logic [31:0] MemMask = ~(32'(MemSize) - 32'd1);

  typedef enum logic [1:0] {KIND_MEM = 2'd0, KIND_GPIO = 2'd1, KIND_ERR = 2'd2} kind_e;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  req_t [NumPorts-1:0] port_req;
  req_t                win_req;
  logic [PtrW-1:0]     win, rr_ptr;
  logic                win_vld;
  kind_e               win_kind;
  int                  arb_idx;
  logic [GpioWidth-1:0] gpio_q, gpio_d;
  logic                resp_valid;
  logic [PtrW-1:0]     resp_port;
  kind_e               resp_kind;

  for (genvar p = 0; p < NumPorts; p++) begin : g_req
    assign port_req[p] = '{we: we_i[p], be: be_i[p], addr: addr_i[p], wdata: wdata_i[p]};
  end

  // Arbitration: scan from index 0 (fixed) or from rr_ptr with wrap (round-robin)
  always_comb begin
    gnt_o   = '0;
    win     = '0;
    win_vld = 1'b0;
    arb_idx = 0;
    for (int i = 0; i < NumPorts; i++) begin
      if (ArbMode == 1) begin
        arb_idx = int'(rr_ptr) + i;
        if (arb_idx >= NumPorts) arb_idx = arb_idx - NumPorts;
      end else begin
        arb_idx = i;
      end
      if (!win_vld && req_i[arb_idx]) begin
        win_vld        = 1'b1;
        win            = PtrW'(arb_idx);
        gnt_o[arb_idx] = 1'b1;
      end
    end
  end

  assign win_req = port_req[win];

  // Address decode of the winning request; SRAM wins over GPIO if they overlap
  always_comb begin
    win_kind = KIND_ERR;
    if ((win_req.addr & MemMask) == MemStart)       win_kind = KIND_MEM;
    else if (win_req.addr[31:2] == GpioAddr[31:2]) win_kind = KIND_GPIO;
  end

  assign mem_req_o   = win_vld && (win_kind == KIND_MEM);
  assign mem_we_o    = mem_req_o & win_req.we;
  assign mem_be_o    = mem_req_o ? win_req.be    : 4'h0;
  assign mem_addr_o  = mem_req_o ? win_req.addr  : 32'h0;
  assign mem_wdata_o = mem_req_o ? win_req.wdata : 32'h0;

  // GPIO byte-lane write; lanes beyond GpioWidth have no backing bits
  always_comb begin
    gpio_d = gpio_q;
    if (win_vld && (win_kind == KIND_GPIO) && win_req.we) begin
      for (int k = 0; k < GpioWidth; k++)
        if (win_req.be[k/8]) gpio_d[k] = win_req.wdata[k];
    end
  end

  // Response tag, RR pointer and GPIO register
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      resp_valid <= 1'b0;
      resp_port  <= '0;
      resp_kind  <= KIND_MEM;
      rr_ptr     <= '0;
      gpio_q     <= '0;
    end else begin
      resp_valid <= win_vld;
      gpio_q     <= gpio_d;
      if (win_vld) begin
        resp_port <= win;
        resp_kind <= win_kind;
        if (ArbMode == 1)
          rr_ptr <= (win == PtrW'(NumPorts - 1)) ? '0 : win + PtrW'(1);
      end
    end
  end

  assign gpio_o = gpio_q;

  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    obi_sram_xbar_port u_port (
      .rsp_vld    (resp_valid && (resp_port == PtrW'(p))),
      .is_mem     (resp_kind == KIND_MEM),
      .is_gpio    (resp_kind == KIND_GPIO),
      .is_err     (resp_kind == KIND_ERR),
      .mem_rdata  (mem_rdata_i),
      .gpio_rdata (32'(gpio_q)),
      .rvalid     (rvalid_o[p]),
      .err        (err_o[p]),
      .rdata      (rdata_o[p])
    );
  end
endmodule
